pipelined_port_alloc: RTL and testbench

- Parametrised, pipelined successor to the sequential BLESS port allocator chain.
- Takes NUM_PORT priority-sorted flits (slot 0 highest priority), each with a productive-port request vector, and assigns every valid flit a unique output port.
- Flits with no free productive port are deflected to a free port. Flits that get no port at all are flagged as dropped.
- One allocation stage per flit slot, registered between slots. Sits between the router's priority sort stage and the crossbar; accepts a new flit set every cycle.

---
 rtl/pipelined_port_alloc.sv | 191 +++++++++++++++++++
 tb/tb_pipelined_port_alloc.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_port_alloc.sv
// pipelined_port_alloc
//
// Pipelined output-port allocator for a bufferless deflection router.
// It sits between the priority sort stage and the crossbar. Each cycle it can
// accept a set of NUM_PORT flits that arrive sorted by priority, with slot 0
// having the highest priority. Each valid flit receives one unique output
// port:
//   - a productive port, if one is still free;
//   - otherwise any free port, and the flit is flagged as deflected;
//   - otherwise no port, and the flit is flagged as dropped.
//
// Pipeline structure:
//   - R0 captures the incoming set.
//   - Stage s decides slot s only and writes its result into R(s+1).
//   - Results leave from RN.
//   - A set sampled at edge E is visible at the outputs after edge E+NUM_PORT.
//
// Parameters:
//   NUM_PORT  number of flit slots and output ports (2..16)
//   CNT_W     width of the statistics counters
//
// Ports:
//   clk, reset    clock and synchronous active-high reset (reset beats stall)
//   stall         freezes every pipeline register; in_valid is ignored
//   in_valid      a flit set is presented this cycle
//   flit_valid    bit i = slot i occupied
//   req_vector    slot i at [i*N +: N], bit j = port j is productive
//   port_avail    bit j = output port j usable for this set
//   out_valid     the outputs hold a completed set
//   alloc_vector  slot i at [i*N +: N], one-hot grant or zero
//   deflect       bit i = flit i got a non-productive port
//   drop          bit i = valid flit i got no port
//
// Optional build macro PORT_ALLOC_STATS_EN adds:
//   clear_stats     synchronous clear of both counters
//   deflect_count   saturating count of deflected flits
//   drop_count      saturating count of dropped flits

module pipelined_port_alloc #(
  parameter int NUM_PORT = 5,
  parameter int CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         in_valid,
  input  logic [NUM_PORT-1:0]          flit_valid,
  input  logic [NUM_PORT*NUM_PORT-1:0] req_vector,
  input  logic [NUM_PORT-1:0]          port_avail,
  output logic                         out_valid,
  output logic [NUM_PORT*NUM_PORT-1:0] alloc_vector,
  output logic [NUM_PORT-1:0]          deflect,
  output logic [NUM_PORT-1:0]          drop
`ifdef PORT_ALLOC_STATS_EN
  ,
  input  logic                         clear_stats,
  output logic [CNT_W-1:0]             deflect_count,
  output logic [CNT_W-1:0]             drop_count
`endif
);

  localparam int N  = NUM_PORT;
  localparam int NN = NUM_PORT * NUM_PORT;
  localparam logic [N-1:0] ONE = N'(1);

  // Pipeline registers. valid/alloc/deflect/drop exist in R0..RN.
  // The request, flit-valid and free-port context is only needed by the
  // stages, so it stops at R(N-1).
  logic            valid_q [0:N];
  logic [NN-1:0]   alloc_q [0:N];
  logic [N-1:0]    defl_q  [0:N];
  logic [N-1:0]    drop_q  [0:N];
  logic [N-1:0]    fv_q    [0:N-1];
  logic [NN-1:0]   req_q   [0:N-1];
  logic [N-1:0]    free_q  [0:N-1];

  // Results of stage s, to be loaded into R(s+1).
  logic [N-1:0]    prod_c  [0:N-1];
  logic [N-1:0]    grant_c [0:N-1];
  logic [N-1:0]    free_n  [0:N-1];
  logic [NN-1:0]   alloc_n [0:N-1];
  logic [N-1:0]    defl_n  [0:N-1];
  logic [N-1:0]    drop_n  [0:N-1];

  // Per-stage grant logic.
  // x & (~x + 1) isolates the lowest set bit, so ties go to the lowest port
  // index. The partial results arrive from R0 as zeros, so each stage only
  // needs to set the bits that belong to its own slot.
  always_comb begin
    for (int s = 0; s < N; s++) begin
      prod_c[s]  = req_q[s][s*N +: N] & free_q[s];
      grant_c[s] = '0;
      defl_n[s]  = defl_q[s];
      drop_n[s]  = drop_q[s];
      alloc_n[s] = alloc_q[s];
      if (fv_q[s][s]) begin
        if (prod_c[s] != '0) begin
          grant_c[s] = prod_c[s] & (~prod_c[s] + ONE);
        end else if (free_q[s] != '0) begin
          grant_c[s]   = free_q[s] & (~free_q[s] + ONE);
          defl_n[s][s] = 1'b1;
        end else begin
          drop_n[s][s] = 1'b1;
        end
      end
      alloc_n[s][s*N +: N] = grant_c[s];
      free_n[s]            = free_q[s] & ~grant_c[s];
    end
  end

  // All registers advance together, so bubbles move through the pipe like
  // data. Reset clears every valid bit, which discards any set in flight.
  // The context fields (fv/req/free) are not reset: without a valid bit
  // their contents are never observed.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k <= N; k++) begin
        valid_q[k] <= 1'b0;
        alloc_q[k] <= '0;
        defl_q[k]  <= '0;
        drop_q[k]  <= '0;
      end
    end else if (!stall) begin
      valid_q[0] <= in_valid;
      alloc_q[0] <= '0;
      defl_q[0]  <= '0;
      drop_q[0]  <= '0;
      fv_q[0]    <= flit_valid;
      req_q[0]   <= req_vector;
      free_q[0]  <= port_avail;
      for (int s = 0; s < N; s++) begin
        valid_q[s+1] <= valid_q[s];
        alloc_q[s+1] <= alloc_n[s];
        defl_q[s+1]  <= defl_n[s];
        drop_q[s+1]  <= drop_n[s];
      end
      for (int s = 0; s < N - 1; s++) begin
        fv_q[s+1]   <= fv_q[s];
        req_q[s+1]  <= req_q[s];
        free_q[s+1] <= free_n[s];
      end
    end
  end

  // Outputs come from RN and are forced to zero for bubbles, so that
  // downstream logic never sees stale grants.
  always_comb begin
    out_valid    = valid_q[N];
    alloc_vector = '0;
    deflect      = '0;
    drop         = '0;
    if (valid_q[N]) begin
      alloc_vector = alloc_q[N];
      deflect      = defl_q[N];
      drop         = drop_q[N];
    end
  end

`ifdef PORT_ALLOC_STATS_EN
  localparam int SW = CNT_W + 5;
  localparam logic [SW-1:0] CMAX = SW'({CNT_W{1'b1}});

  function automatic logic [4:0] popcnt(input logic [N-1:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + {4'b0, v[i]};
    end
    return c;
  endfunction

  logic [SW-1:0] dsum;
  logic [SW-1:0] psum;

  assign dsum = SW'(deflect_count) + SW'(popcnt(defl_n[N-1]));
  assign psum = SW'(drop_count) + SW'(popcnt(drop_n[N-1]));

  // Count the flags as the final stage loads them into RN. The sums are
  // kept wide so that saturation can be detected without wrapping.
  always_ff @(posedge clk) begin
    if (reset || clear_stats) begin
      deflect_count <= '0;
      drop_count    <= '0;
    end else if (!stall && valid_q[N-1]) begin
      deflect_count <= (dsum > CMAX) ? {CNT_W{1'b1}} : dsum[CNT_W-1:0];
      drop_count    <= (psum > CMAX) ? {CNT_W{1'b1}} : psum[CNT_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_pipelined_port_alloc.sv
// tb_pipelined_port_alloc
//
// Directed testbench for pipelined_port_alloc with NUM_PORT=5.
// Each expected allocation below was worked out by hand from the slot-order
// grant rules. When PORT_ALLOC_STATS_EN is defined, the bench also checks
// the saturating counters, using CNT_W=4.

module tb_pipelined_port_alloc;

  localparam int N  = 5;
  localparam int NN = N * N;

  logic          clk;
  logic          reset;
  logic          stall;
  logic          in_valid;
  logic [N-1:0]  flit_valid;
  logic [NN-1:0] req_vector;
  logic [N-1:0]  port_avail;
  logic          out_valid;
  logic [NN-1:0] alloc_vector;
  logic [N-1:0]  deflect;
  logic [N-1:0]  drop;
`ifdef PORT_ALLOC_STATS_EN
  logic          clear_stats;
  logic [3:0]    deflect_count;
  logic [3:0]    drop_count;
`endif

  int vectors;
  int errors;

  pipelined_port_alloc #(
    .NUM_PORT(N)
`ifdef PORT_ALLOC_STATS_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .in_valid     (in_valid),
    .flit_valid   (flit_valid),
    .req_vector   (req_vector),
    .port_avail   (port_avail),
    .out_valid    (out_valid),
    .alloc_vector (alloc_vector),
    .deflect      (deflect),
    .drop         (drop)
`ifdef PORT_ALLOC_STATS_EN
    ,
    .clear_stats  (clear_stats),
    .deflect_count(deflect_count),
    .drop_count   (drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Directed sets.
  // Requests are packed as {req4, req3, req2, req1, req0}.
  localparam logic [NN-1:0] REQ_A = {5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001};
  localparam logic [NN-1:0] REQ_B = {5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001};
  localparam logic [NN-1:0] REQ_C = {5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100};
  localparam logic [NN-1:0] ALC_A = REQ_A;
  localparam logic [NN-1:0] ALC_B = {5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001};
  localparam logic [NN-1:0] ALC_C = {5'b00000, 5'b00000, 5'b00000, 5'b00010, 5'b00001};

  // Advance one clock; inputs are then driven, and outputs sampled, 1 ns
  // after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkSet(input string tag, input logic ev, input logic [NN-1:0] ea,
                          input logic [N-1:0] ed, input logic [N-1:0] edr);
    checkOutput({tag, ".valid"}, 32'(out_valid), 32'(ev));
    checkOutput({tag, ".alloc"}, 32'(alloc_vector), 32'(ea));
    checkOutput({tag, ".deflect"}, 32'(deflect), 32'(ed));
    checkOutput({tag, ".drop"}, 32'(drop), 32'(edr));
  endtask

  // Present one set for exactly one edge, then drop in_valid.
  task automatic applyStimulus(input logic [N-1:0] fv, input logic [N-1:0] avail,
                               input logic [NN-1:0] req);
    in_valid   = 1'b1;
    flit_valid = fv;
    port_avail = avail;
    req_vector = req;
    tick();
    in_valid = 1'b0;
  endtask

  // Send a single set through an otherwise empty pipe.
  // Checks that out_valid is still low one cycle early, that the result
  // arrives after edge E+5, and that out_valid drops again afterwards.
  task automatic runSingle(input string tag, input logic [N-1:0] fv, input logic [N-1:0] avail,
                           input logic [NN-1:0] req, input logic [NN-1:0] ea,
                           input logic [N-1:0] ed, input logic [N-1:0] edr);
    applyStimulus(fv, avail, req);
    repeat (4) tick();
    checkOutput({tag, ".early"}, 32'(out_valid), 32'd0);
    tick();
    checkSet(tag, 1'b1, ea, ed, edr);
    tick();
    checkOutput({tag, ".after"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    vectors    = 0;
    errors     = 0;
    reset      = 1'b1;
    stall      = 1'b0;
    in_valid   = 1'b0;
    flit_valid = '0;
    req_vector = '0;
    port_avail = '0;
`ifdef PORT_ALLOC_STATS_EN
    clear_stats = 1'b0;
`endif
    tick();
    tick();
    reset = 1'b0;
    checkSet("reset", 1'b0, '0, '0, '0);

    $display("[TB] distinct productive ports");
    runSingle("distinct", 5'b11111, 5'b11111, REQ_A, ALC_A, 5'b00000, 5'b00000);

    $display("[TB] contention and deflection");
    runSingle("contend", 5'b11111, 5'b11111, REQ_B, ALC_B, 5'b11110, 5'b00000);

    $display("[TB] unavailable ports");
    runSingle("unavail", 5'b00111, 5'b00011, REQ_C, ALC_C, 5'b00011, 5'b00100);

    // Sparse slots and an empty request.
    // slot0 deflects to port 0, slot2 wins port 4, and slot4 deflects to
    // the lowest port still free (port 1).
    runSingle("sparse", 5'b10101, 5'b11111,
              {5'b10000, 5'b00000, 5'b10000, 5'b00000, 5'b00000},
              {5'b00010, 5'b00000, 5'b10000, 5'b00000, 5'b00001},
              5'b10001, 5'b00000);

    // Several productive bits: the lowest free productive port wins.
    runSingle("multi", 5'b00011, 5'b11111,
              {5'b00000, 5'b00000, 5'b00000, 5'b01100, 5'b01100},
              {5'b00000, 5'b00000, 5'b00000, 5'b01000, 5'b00100},
              5'b00000, 5'b00000);

    // A valid set with no occupied slots still produces out_valid.
    runSingle("empty", 5'b00000, 5'b11111, REQ_B, '0, 5'b00000, 5'b00000);

    $display("[TB] back-to-back sets with stall");
    applyStimulus(5'b11111, 5'b11111, REQ_A);
    applyStimulus(5'b11111, 5'b11111, REQ_B);
    applyStimulus(5'b00111, 5'b00011, REQ_C);
    repeat (3) tick();
    checkSet("b2b.a", 1'b1, ALC_A, 5'b00000, 5'b00000);
    stall      = 1'b1;
    in_valid   = 1'b1;
    flit_valid = 5'b11111;
    port_avail = 5'b11111;
    req_vector = REQ_B;
    tick();
    checkSet("stall1.a", 1'b1, ALC_A, 5'b00000, 5'b00000);
    tick();
    checkSet("stall2.a", 1'b1, ALC_A, 5'b00000, 5'b00000);
    stall    = 1'b0;
    in_valid = 1'b0;
    tick();
    checkSet("b2b.b", 1'b1, ALC_B, 5'b11110, 5'b00000);
    tick();
    checkSet("b2b.c", 1'b1, ALC_C, 5'b00011, 5'b00100);
    tick();
    checkSet("b2b.end", 1'b0, '0, '0, '0);
    tick();
    checkOutput("stall.ignored", 32'(out_valid), 32'd0);

    $display("[TB] reset mid-flight");
    repeat (6) tick();
    applyStimulus(5'b11111, 5'b11111, REQ_A);
    applyStimulus(5'b11111, 5'b11111, REQ_B);
    applyStimulus(5'b00111, 5'b00011, REQ_C);
    reset = 1'b1;
    stall = 1'b1;
    tick();
    reset = 1'b0;
    stall = 1'b0;
    checkSet("rst.now", 1'b0, '0, '0, '0);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkSet($sformatf("rst.idle%0d", i), 1'b0, '0, '0, '0);
    end
    runSingle("rst.next", 5'b11111, 5'b11111, REQ_B, ALC_B, 5'b11110, 5'b00000);

`ifdef PORT_ALLOC_STATS_EN
    $display("[TB] statistics counters");
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    checkOutput("stats.clr0.defl", 32'(deflect_count), 32'd0);
    checkOutput("stats.clr0.drop", 32'(drop_count), 32'd0);
    repeat (4) applyStimulus(5'b11111, 5'b11111, REQ_B);
    repeat (5) tick();
    checkOutput("stats.sat.defl", 32'(deflect_count), 32'd15);
    checkOutput("stats.sat.drop", 32'(drop_count), 32'd0);
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    checkOutput("stats.clr1.defl", 32'(deflect_count), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
